seq_controller: RTL
===================

Name: seq_controller

Overview:
- Parametrised successor to the processor's combinational decode/control unit.
- Owns the instruction register, the T0..T3 step counter and a valid/ready instruction-fetch handshake. It drives the same datapath strobes as before (register file, A/G registers, ALU, external bus).
- Adds a stall input, illegal-opcode detection, signed/unsigned immediates, a register count set by parameter, and a retired-instruction counter.
- Sits between the instruction source/external data bus and the datapath.

Parameters:
- DATA_W, 10: instruction/data width.
- REG_AW, 2: register-address width (2**REG_AW registers). Must satisfy DATA_W >= 2+2*REG_AW+4.
- IMM_SIGNED, 0: 0 = zero-extend immediate, 1 = sign-extend immediate to DATA_W.
- COUNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr_valid  in  1  instruction word present on instr.
- instr  in  DATA_W  instruction word (external bus).
- stall  in  1  freeze sequencing.
- instr_ready  out  1  controller is in T0 and accepts an instruction.
- IRin  out  1  instruction-register load strobe (to datapath).
- Ext  out  1  drive external data onto the bus.
- ENR, ENW  out  1 each  register-file read/write enable.
- Rout, Rin  out  REG_AW each  register-file read/write address.
- Ain, Gin, Gout  out  1 each  A load, G load, G to bus.
- ALUcont  out  4  ALU operation code.
- immediate  out  1  select IMM as the ALU B operand.
- IMM  out  DATA_W  extended immediate.
- done  out  1  last step of the instruction.
- illegal  out  1  undefined instruction was retired.
- step  out  2  current T step.
- instr_count  out  COUNT_W  count of legal instructions retired.

Behaviour:
- Fields, taken from the internal IR:
  - cls = IR[DATA_W-1:DATA_W-2].
  - Rx = the next REG_AW bits.
  - Ry = the REG_AW bits below Rx.
  - op = IR[3:0].
  - imm = all bits below Rx.
  - IMM = imm extended per IMM_SIGNED while cls=1x; 0 otherwise.
- Reset (asynchronous, rst_n=0), also when asserted mid-instruction:
  - step=0 (T0), IR=0, instr_count=0.
  - Every strobe, Rin, Rout, ALUcont, IMM, done and illegal = 0.
  - instr_ready = 1.
  - No partial register write can occur.
- Control outputs are combinational from step, IR and stall. step, IR and instr_count are registered.
- T0:
  - instr_ready = !stall.
  - If instr_valid && instr_ready: IRin=1, Ext=1, IR<=instr, step<=1. Otherwise hold T0 with all strobes 0.
- Step sequences below. "end" means done=1 and step<=0 next cycle; no instruction is accepted on a done cycle.
  - LOAD (cls 00, op 0000): T1: Ext, ENW, Rin=Rx, end.
  - COPY (cls 00, op 0001): T1: Rout=Ry, ENR, Rin=Rx, ENW, end.
  - INV / FLP (cls 00, op 0100 / 0101):
    - T1: Rout=Ry, ENR, Gin, ALUcont=op.
    - T2: Gout, ENW, Rin=Rx, end.
  - Binary ops ADD, SUB, AND, OR, XOR, LSL, LSR, ASR (cls 00, op 0010, 0011, 0110..1011):
    - T1: Ain, Rout=Rx, ENR.
    - T2: Rout=Ry, ENR, Gin, ALUcont=op.
    - T3: Gout, ENW, Rin=Rx, end.
  - ADDI (cls 10) / SUBI (cls 11):
    - T1: Ain, Rout=Rx, ENR.
    - T2: immediate, IMM, Gin, ALUcont = 0010 (ADDI) / 0011 (SUBI).
    - T3: Gout, ENW, Rin=Rx, end.
    - op bits belong to imm and are not decoded.
  - Illegal (cls 01, or cls 00 with op 1100..1111):
    - T1: illegal=1, done=1, all other strobes 0.
    - No register write; instr_count unchanged.
- Exactly one opcode class is decoded per instruction; immediate classes never also fire a register-register sequence.
- stall=1 in T1..T3:
  - step holds.
  - ENR, ENW, Ain, Gin, Gout, Ext, immediate, done and illegal are forced to 0.
  - Rin, Rout, ALUcont and IMM keep their decoded values.
  - On release the step resumes exactly where it stopped.
- instr_count increments by 1 on each non-illegal done cycle and wraps modulo 2**COUNT_W.
- instr_valid is ignored outside T0; step never exceeds 3.

Test Plan:
- Reset, then ADD R1,R2 (instr=0x062) with valid held -> IRin and Ext at T0. T1: Ain, Rout=1. T2: Rout=2, Gin, ALUcont=0010. T3: Gout, ENW, Rin=1, done. instr_count=1.
- ADDI R3,#5 (0x2C5), IMM_SIGNED=0 -> T2: immediate=1, IMM=0x005, ALUcont=0010. T3: Rin=3, ENW.
- IMM_SIGNED=1, SUBI R0,#-1 (0x33F) -> T2: IMM=0x3FF, ALUcont=0011. T3: ENW, Rin=0.
- Illegal 0x00C, then 0x140 -> each gives T1 illegal=1, done=1 and ENW never high; instr_count unchanged. Next valid LOAD R2 (0x080) accepted in the following T0 -> T1: Ext, ENW, Rin=2.
- ADD 0x062 with stall=1 for 3 cycles during T2 -> step stays 2, Gin=0 while stalled, Rout stays 2. Gin pulses once on release; total latency 4+3 cycles.
- rst_n low during T2 of SUB -> asynchronously step=0, ENW/Gin=0, instr_count=0, instr_ready=1. 300 back-to-back COPYs with COUNT_W=8 -> instr_count=44 (wrap).

Source files
------------

// File: rtl/seq_controller_if.sv
// seq_controller_if: instruction-fetch handshake and datapath strobes of seq_controller.
interface seq_controller_if #(
   parameter int DATA_W = 10,
   parameter int REG_AW = 2,
   parameter int COUNT_W = 16
);
   logic instr_valid, stall, instr_ready, IRin, Ext, ENR, ENW, Ain, Gin, Gout, immediate, done, illegal;
   logic [DATA_W-1:0] instr, IMM;
   logic [REG_AW-1:0] Rout, Rin;
   logic [3:0] ALUcont;
   logic [1:0] step;
   logic [COUNT_W-1:0] instr_count;
   modport master(
      input instr_valid, instr, stall,
      output instr_ready, IRin, Ext, ENR, ENW, Rout, Rin, Ain, Gin, Gout, ALUcont, immediate, IMM, done,
      illegal, step, instr_count
   );
   modport slave(
      output instr_valid, instr, stall,
      input instr_ready, IRin, Ext, ENR, ENW, Rout, Rin, Ain, Gin, Gout, ALUcont, immediate, IMM, done,
      illegal, step, instr_count
   );
endinterface

// File: rtl/seq_controller.sv
// seq_controller: instruction register, T0..T3 sequencer and decode of datapath strobes.
module seq_controller #(
   parameter int DATA_W = 10,
   parameter int REG_AW = 2,
   parameter int IMM_SIGNED = 0,
   parameter int COUNT_W = 16
) (
   input logic clk,
   input logic rst_n,
   seq_controller_if.master bus
);
   localparam int IW = DATA_W - 2 - REG_AW;
   typedef enum logic [1:0] {T0, T1, T2, T3} step_t;
   step_t step_q, step_d;
   logic [DATA_W-1:0] ir_q, ir_d;
   logic [COUNT_W-1:0] cnt_q, cnt_d;
   logic [1:0] cls;
   logic [REG_AW-1:0] rx, ry;
   logic [3:0] op;
   logic [IW-1:0] imm;
   logic t0, t1, t2, t3, act, accept;
   logic is_rr, is_imm, load, copy, un, bin, ill;
   logic wr_rx, rd_rx, rd_ry, alu_op, fin;
   assign cls = ir_q[DATA_W-1 -: 2];
   assign rx = ir_q[DATA_W-3 -: REG_AW];
   assign ry = ir_q[DATA_W-3-REG_AW -: REG_AW];
   assign op = ir_q[3:0];
   assign imm = ir_q[IW-1:0];
   assign is_rr = cls == 2'b00;
   assign is_imm = cls[1];
   assign load = is_rr && op == 4'd0;
   assign copy = is_rr && op == 4'd1;
   assign un = is_rr && (op == 4'd4 || op == 4'd5);
   assign bin = is_rr && (op inside {4'd2, 4'd3, [4'd6:4'd11]});
   assign ill = cls == 2'b01 || (is_rr && op >= 4'd12);
   assign t0 = step_q == T0;
   assign t1 = step_q == T1;
   assign t2 = step_q == T2;
   assign t3 = step_q == T3;
   assign act = !bus.stall;
   assign accept = t0 && act && bus.instr_valid;
   // Register selects and ALU code survive a stall; only the enables are gated by act.
   assign wr_rx = (t1 && (load || copy)) || (t2 && un) || t3;
   assign rd_ry = (t1 && (copy || un)) || (t2 && bin);
   assign rd_rx = t1 && (bin || is_imm);
   assign alu_op = (t1 && un) || (t2 && bin);
   assign fin = (t1 && (load || copy || ill)) || (t2 && un) || t3;
   assign bus.instr_ready = t0 && act;
   assign bus.IRin = accept;
   assign bus.Ext = accept || (act && t1 && load);
   assign bus.ENR = act && (rd_rx || rd_ry);
   assign bus.ENW = act && wr_rx;
   assign bus.Rout = rd_ry ? ry : rd_rx ? rx : '0;
   assign bus.Rin = wr_rx ? rx : '0;
   assign bus.Ain = act && rd_rx;
   assign bus.Gin = act && ((t1 && un) || (t2 && (bin || is_imm)));
   assign bus.Gout = act && ((t2 && un) || t3);
   assign bus.ALUcont = alu_op ? op : (t2 && is_imm) ? {3'b001, cls[0]} : 4'd0;
   assign bus.immediate = act && t2 && is_imm;
   assign bus.IMM = !is_imm ? '0 :
                    IMM_SIGNED != 0 ? {{(DATA_W-IW){imm[IW-1]}}, imm} : {{(DATA_W-IW){1'b0}}, imm};
   assign bus.done = act && fin;
   assign bus.illegal = act && t1 && ill;
   assign bus.step = step_q;
   assign bus.instr_count = cnt_q;
   assign step_d = accept ? T1 : (t0 || !act) ? step_q : fin ? T0 : step_t'(step_q + 2'd1);
   assign ir_d = accept ? bus.instr : ir_q;
   assign cnt_d = cnt_q + COUNT_W'(act && fin && !ill);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         step_q <= T0;
         ir_q <= '0;
         cnt_q <= '0;
      end else begin
         step_q <= step_d;
         ir_q <= ir_d;
         cnt_q <= cnt_d;
      end
endmodule
